// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl_pkg
// Description : Shared types and constants for the byte-wide memory
//               controller (FSM states, LSB length codes, IO region tag,
//               default icache line size).
// Revision    : 1.0  initial release
// ============================================================================
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_IFETCH = 2'd1,
        ST_LOAD   = 2'd2,
        ST_STORE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        LEN_BYTE = 2'd0,
        LEN_HALF = 2'd1,
        LEN_WORD = 2'd2,
        LEN_RSVD = 2'd3
    } lsb_len_t;

    localparam int         LINE_BYTES_DEF = 8;
    localparam logic [1:0] IO_ADDR_HI_DEF = 2'b11;

    // Bit positions inside the one-hot grant vector
    localparam int GNT_IC  = 0;
    localparam int GNT_LSB = 1;

    // Byte count of an LSB access; the reserved code behaves as a word
    function automatic logic [2:0] len_to_bytes(input logic [1:0] len);
        case (len)
            LEN_BYTE: len_to_bytes = 3'd1;
            LEN_HALF: len_to_bytes = 3'd2;
            default:  len_to_bytes = 3'd4;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_ctrl_arb.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl_arb
// Description : Requester arbitration for mem_ctrl. Combinational one-hot
//               grant; when MEM_ARB_RR_EN is defined a last-grant register
//               makes ties round-robin, otherwise the LSB wins every tie.
// Revision    : 1.0  initial release
// ============================================================================
module mem_ctrl_arb
    import mem_ctrl_pkg::*;
(
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       rdy_in,
    input  logic       idle,
    input  logic       ic_req,
    input  logic       lsb_req,
    input  logic       ic_done,
    input  logic       lsb_done,
    input  logic       clear_signal,
    input  logic       lsb_wr,
    output logic [1:0] grant
);

    logic ic_ok;
    logic lsb_ok;
    logic tie_to_ic;

    // Qualify requests: a requester being answered this cycle is ignored,
    // and a flush blocks fetches and loads but not committed stores
    always_comb begin
        ic_ok  = ic_req & ~ic_done & ~clear_signal;
        lsb_ok = lsb_req & ~lsb_done & ~(clear_signal & ~lsb_wr);
    end

`ifdef MEM_ARB_RR_EN
    logic last_lsb;

    // Remember who was granted last; reset favours the icache on the first tie
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            last_lsb <= 1'b1;
        end else if (rdy_in && (grant != 2'b00)) begin
            last_lsb <= grant[GNT_LSB];
        end
    end

    assign tie_to_ic = last_lsb;
`else
    logic unused_arb;
    assign unused_arb = &{1'b0, clk_in, rst_in, rdy_in};
    assign tie_to_ic  = 1'b0;
`endif

    // One-hot grant, only offered while the controller is idle
    always_comb begin
        grant = 2'b00;
        if (idle) begin
            if (ic_ok && lsb_ok) begin
                grant[GNT_IC]  = tie_to_ic;
                grant[GNT_LSB] = ~tie_to_ic;
            end else if (ic_ok) begin
                grant[GNT_IC] = 1'b1;
            end else if (lsb_ok) begin
                grant[GNT_LSB] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl
// Description : Shares one byte-wide RAM port between icache line fetches
//               and LSB loads/stores. Sequences each access as back-to-back
//               byte transfers, little-endian, with a one-cycle done pulse.
//               Define MEM_ARB_RR_EN for round-robin tie arbitration
//               (default build: LSB has fixed priority).
// Revision    : 1.0  initial release
// ============================================================================
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int         LINE_BYTES = LINE_BYTES_DEF,
    parameter logic [1:0] IO_ADDR_HI = IO_ADDR_HI_DEF
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    clear_signal,
    input  logic                    ic_signal,
    input  logic [31:0]             ic_addr,
    output logic                    ic_done,
    output logic [8*LINE_BYTES-1:0] ic_data,
    input  logic                    lsb_signal,
    input  logic                    lsb_wr,
    input  logic [31:0]             lsb_addr,
    input  logic [1:0]              lsb_len,
    input  logic [31:0]             lsb_wdata,
    output logic                    lsb_done,
    output logic [31:0]             lsb_rdata,
    input  logic [7:0]              mem_din,
    output logic [7:0]              mem_dout,
    output logic [31:0]             mem_a,
    output logic                    mem_wr,
    input  logic                    io_buffer_full
);

    localparam int CNT_W = $clog2(LINE_BYTES + 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] len;
    logic [CNT_W-1:0] lane;
    logic [CNT_W-1:0] cnt_inc;
    logic [31:0]      wdata;
    logic [1:0]       grant;
    logic             io_stall;

    // Reads capture the byte addressed one cycle earlier
    assign lane    = cnt - CNT_W'(1);
    assign cnt_inc = cnt + CNT_W'(1);

    mem_ctrl_arb u_arb (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .idle         (state == ST_IDLE),
        .ic_req       (ic_signal),
        .lsb_req      (lsb_signal),
        .ic_done      (ic_done),
        .lsb_done     (lsb_done),
        .clear_signal (clear_signal),
        .lsb_wr       (lsb_wr),
        .grant        (grant)
    );

    // State register; a pause freezes it
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state <= ST_IDLE;
        end else if (rdy_in) begin
            state <= state_next;
        end
    end

    // Next state, IO back-pressure and the write strobe
    always_comb begin
        state_next = state;
        io_stall   = 1'b0;
        mem_wr     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant[GNT_IC]) begin
                    state_next = ST_IFETCH;
                end else if (grant[GNT_LSB]) begin
                    state_next = lsb_wr ? ST_STORE : ST_LOAD;
                end
            end
            ST_IFETCH, ST_LOAD: begin
                if (clear_signal || (cnt == len)) begin
                    state_next = ST_IDLE;
                end
            end
            ST_STORE: begin
                io_stall = (mem_a[17:16] == IO_ADDR_HI) && io_buffer_full;
                mem_wr   = rdy_in && !io_stall;
                if (!io_stall && (cnt == len - CNT_W'(1))) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Address/data sequencing, byte capture and done pulses
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            cnt       <= '0;
            len       <= '0;
            wdata     <= '0;
            mem_a     <= '0;
            mem_dout  <= '0;
            ic_done   <= 1'b0;
            lsb_done  <= 1'b0;
            ic_data   <= '0;
            lsb_rdata <= '0;
        end else if (rdy_in) begin
            ic_done  <= 1'b0;
            lsb_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant[GNT_IC]) begin
                        mem_a   <= ic_addr;
                        len     <= CNT_W'(LINE_BYTES);
                        cnt     <= '0;
                        ic_data <= '0;
                    end else if (grant[GNT_LSB]) begin
                        mem_a    <= lsb_addr;
                        len      <= CNT_W'(len_to_bytes(lsb_len));
                        cnt      <= '0;
                        wdata    <= lsb_wdata;
                        mem_dout <= lsb_wdata[7:0];
                        if (!lsb_wr) begin
                            lsb_rdata <= '0;
                        end
                    end
                end
                ST_IFETCH, ST_LOAD: begin
                    if (clear_signal) begin
                        cnt <= '0;
                    end else begin
                        if (cnt != '0) begin
                            if (state == ST_IFETCH) begin
                                ic_data[{lane, 3'b000} +: 8] <= mem_din;
                            end else begin
                                lsb_rdata[{lane[1:0], 3'b000} +: 8] <= mem_din;
                            end
                        end
                        if (cnt == len) begin
                            cnt <= '0;
                            if (state == ST_IFETCH) begin
                                ic_done <= 1'b1;
                            end else begin
                                lsb_done <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt_inc;
                            // Hold the last address instead of touching base+n
                            if (cnt_inc != len) begin
                                mem_a <= mem_a + 32'd1;
                            end
                        end
                    end
                end
                ST_STORE: begin
                    if (!io_stall) begin
                        if (cnt == len - CNT_W'(1)) begin
                            cnt      <= '0;
                            lsb_done <= 1'b1;
                        end else begin
                            cnt      <= cnt_inc;
                            mem_a    <= mem_a + 32'd1;
                            mem_dout <= wdata[{cnt_inc[1:0], 3'b000} +: 8];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller that shares the single byte-wide RAM port between the instruction cache (8-byte line fetches) and the load/store buffer (1/2/4-byte loads and stores). It arbitrates between the two requesters and sequences each access as back-to-back byte transfers. It assembles or splits data little-endian and returns a one-cycle done pulse. It sits between `instr_cache`/LSB and the top-level RAM/IO bus.

## Interface
- `LINE_BYTES`, 8: bytes per icache line fetch; `ic_data` width is 8*LINE_BYTES.
- `IO_ADDR_HI`, 2'b11: value of `addr[17:16]` that marks the IO region.
- `clk_in` in 1: system clock; single clock domain.
- `rst_in` in 1: synchronous, active-low reset.
- `rdy_in` in 1: pause; low freezes all state.
- `clear_signal` in 1: misprediction flush.
- `ic_signal` in 1: icache fetch request, held until `ic_done`.
- `ic_addr` in 32: line base address.
- `ic_done` out 1: one-cycle pulse when `ic_data` is valid.
- `ic_data` out 64: fetched line, byte 0 in [7:0].
- `lsb_signal` in 1: LSB request, held until `lsb_done`.
- `lsb_wr` in 1: 1 = store, 0 = load.
- `lsb_addr` in 32: byte address.
- `lsb_len` in 2: 0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes; 3 is reserved and treated as 4.
- `lsb_wdata` in 32: store data, low bytes used.
- `lsb_done` out 1: one-cycle pulse on completion.
- `lsb_rdata` out 32: load data, zero-extended; sign extension is done by the LSB.
- `mem_din` in 8: RAM read data, valid one cycle after address.
- `mem_dout` out 8: RAM write data.
- `mem_a` out 32: RAM address.
- `mem_wr` out 1: write strobe, gated by `rdy_in`.
- `io_buffer_full` in 1: UART buffer full.

## Operation
- States:
  - IDLE
  - IFETCH
  - LOAD
  - STORE
- Byte counter `cnt` runs 0..n-1, where n = `LINE_BYTES` or the LSB length.
- IDLE arbitration:
  - A requester whose done is high this cycle is ignored.
  - Only one requester present: it is granted.
  - Both present: priority follows Configuration.
  - Grant latches the base address, length and write data, and resets `cnt`=0.
- IFETCH and LOAD:
  - The controller drives `mem_a`=base+k.
  - Byte k arrives on `mem_din` one cycle later and is placed in lane k.
  - After the last byte is captured, the controller pulses done and returns to IDLE.
- STORE:
  - Each cycle drives `mem_a`=base+k, `mem_dout`=wdata[8k+7:8k], `mem_wr`=1.
  - After byte n-1, pulses `lsb_done` and returns to IDLE.
- IO stall: in STORE, if `mem_a[17:16]`==`IO_ADDR_HI` and `io_buffer_full`=1:
  - `mem_wr`=0 that cycle.
  - The byte and `cnt` are held, and the write retries next cycle.
- `clear_signal`=1 with `rdy_in`=1:
  - IFETCH/LOAD: abort to IDLE, no done pulse, `mem_wr`=0.
  - STORE: continues to completion, because stores are already committed.
  - IDLE: ic and load requests are not granted that cycle; a store request may be granted.
- `rdy_in`=0: no state, counter or output register changes; `mem_wr` is forced to 0.
- Unaligned addresses need no special handling, since bytes are accessed sequentially; address arithmetic wraps modulo 2^32.

## Timing
- Grant edge G, meaning the request is sampled in IDLE.
- `mem_a`=base is valid in cycle G+1.
- Read of n bytes:
  - Byte k is on `mem_din` in cycle G+2+k.
  - Done is high in cycle G+n+2; icache line fetch: G+10.
- Write of n bytes:
  - Byte k is written in cycle G+1+k.
  - `lsb_done` is high in cycle G+n+1, plus one cycle per IO stall cycle.
- Done pulses last exactly one cycle. The next grant is possible no earlier than the cycle after done.
- Reset (`rst_in`=0 at an edge), taking effect from any state:
  - State → IDLE, `cnt`=0.
  - `ic_done`=0, `lsb_done`=0, `mem_wr`=0, `mem_a`=0, `mem_dout`=0.
  - `ic_data`=0, `lsb_rdata`=0.
  - Last-grant = LSB, so the first tie goes to the icache.
  - No done pulse is produced for an access in progress.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin.
  - On a tie, the requester not granted last wins.
  - Last-grant updates on every grant.
- `MEM_ARB_RR_EN` undefined: fixed priority, LSB always wins a tie. The last-grant register is absent.

## Structure
- Shared package/header `mem_ctrl_pkg` holds:
  - State encodings (IDLE/IFETCH/LOAD/STORE).
  - `lsb_len` codes.
  - `IO_ADDR_HI`.
  - The `LINE_BYTES` default.
- One sub-module, `mem_ctrl_arb`: combinational grant plus the last-grant register. It takes both request lines, both done flags, `clear_signal` and `lsb_wr`, and produces a one-hot grant.

## Test plan
- **Icache fetch:** `ic_signal`, `ic_addr`=0x100, RAM bytes 0x11..0x88 → `ic_done` at G+10 with `ic_data`=0x8877665544332211, a single pulse.
- **Halfword store:** `lsb_wr`=1, `lsb_len`=1, `lsb_addr`=0x200, `lsb_wdata`=0xABCD → cycle G+1 writes 0x200←0xCD, G+2 writes 0x201←0xAB, `lsb_done` at G+3.
- **Tie:** both requests asserted simultaneously after reset.
  - With `MEM_ARB_RR_EN`: icache first, then LSB.
  - Without `MEM_ARB_RR_EN`: LSB first.
- **Clear during load:** `clear_signal` at G+3 of a word load → back to IDLE, no `lsb_done`, `mem_wr` stays 0. A store issued under the same conditions still writes all 4 bytes.
- **IO stall:** store byte to 0x30000 with `io_buffer_full`=1 for 3 cycles → `mem_wr` low for 3 cycles, then one write, `lsb_done` at G+5.
- **Pause and reset:** `rdy_in`=0 mid-fetch for 2 cycles → done delayed by 2. Then `rst_in`=0 mid-fetch → all outputs zero and no done pulse.
